// File: rtl/uart_tx_buf_if.sv
// Byte-FIFO write side and UART transmitter load handshake for uart_tx_buf.
// slave modport is the buffer; master is the producer/transmitter side.
interface uart_tx_buf_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      wr_data;
    logic            wr_en;
    logic            full;
    logic            empty;
    logic [ADDR_W:0] count;
    logic            overflow;
    logic [7:0]      tx_data;
    logic            tx_vld;
    logic            tx_rdy;

    modport slave (
        input  wr_data, wr_en, tx_rdy,
        output full, empty, count, overflow,
        output tx_data, tx_vld
    );

    modport master (
        output wr_data, wr_en, tx_rdy,
        input  full, empty, count, overflow,
        input  tx_data, tx_vld
    );
endinterface

// File: rtl/uart_tx_buf.sv
// Byte FIFO feeding a UART transmitter one character per load strobe.
// Define HEX_ASCII_EN to send each byte as two uppercase ASCII hex chars.
module uart_tx_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic          clk,
    input logic          rst_n,
    uart_tx_buf_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]      mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] wr_nxt;
    logic [ADDR_W:0] rd_nxt;
    logic [ADDR_W:0] cnt_nxt;
    logic [7:0]      head;
    logic            push;
    logic            pop;
    logic            seen_busy;
    state_t          state;
`ifdef HEX_ASCII_EN
    logic [3:0]      lo_nib;
    logic            nib;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction
`endif

    assign push    = bus.wr_en && !bus.full;
    assign pop     = (state == IDLE) && !bus.empty && bus.tx_rdy;
    assign wr_nxt  = wr_ptr + {{ADDR_W{1'b0}}, push};
    assign rd_nxt  = rd_ptr + {{ADDR_W{1'b0}}, pop};
    assign cnt_nxt = wr_nxt - rd_nxt;
    assign head    = mem[rd_ptr[ADDR_W-1:0]];

    // Storage needs no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.count    <= '0;
            bus.empty    <= 1'b1;
            bus.full     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            bus.count <= cnt_nxt;
            bus.empty <= (cnt_nxt == '0);
            bus.full  <= (cnt_nxt == FULL_CNT);
            if (bus.wr_en && bus.full) bus.overflow <= 1'b1;
        end
    end

    // HOLD only releases after tx_rdy has been seen low, so a slow
    // transmitter cannot be handed two loads back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            seen_busy   <= 1'b0;
            bus.tx_vld  <= 1'b0;
            bus.tx_data <= 8'h00;
`ifdef HEX_ASCII_EN
            lo_nib      <= 4'h0;
            nib         <= 1'b0;
`endif
        end else begin
            bus.tx_vld <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        state      <= SEND;
                        bus.tx_vld <= 1'b1;
`ifdef HEX_ASCII_EN
                        bus.tx_data <= hex(head[7:4]);
                        lo_nib      <= head[3:0];
                        nib         <= 1'b0;
`else
                        bus.tx_data <= head;
`endif
                    end
                end
                SEND: begin
                    state     <= HOLD;
                    seen_busy <= 1'b0;
                end
                HOLD: begin
                    if (!bus.tx_rdy) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
`ifdef HEX_ASCII_EN
                        if (!nib) begin
                            state       <= SEND;
                            bus.tx_vld  <= 1'b1;
                            bus.tx_data <= hex(lo_nib);
                            nib         <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf with a busy-window UART model.
// Expected characters are queued on each accepted write, popped on tx_vld.
module tb_uart_tx_buf;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic gate  = 1'b0;
    int   busy  = 0;

    always #5 clk = ~clk;

    uart_tx_buf_if #(.ADDR_W(ADDR_W)) bus ();

    uart_tx_buf #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    assign bus.tx_rdy = gate && (busy == 0);

    int         checks  = 0;
    int         passes  = 0;
    int         pushed  = 0;
    int         started = 0;
    int         chars   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic logic [7:0] asc(input logic [3:0] n);
        int v;
        v = int'(n);
        return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);
    endfunction

    task automatic push_exp(input logic [7:0] b);
        pushed++;
`ifdef HEX_ASCII_EN
        exp_q.push_back(asc(b[7:4]));
        exp_q.push_back(asc(b[3:0]));
`else
        exp_q.push_back(b);
`endif
    endtask

    // One-cycle write; only counted as accepted when the model is not full.
    task automatic wr(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        if (pushed - started < DEPTH) push_exp(b);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // UART model: each load keeps tx_rdy low for 10 cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 0;
        end else if (bus.tx_vld) begin
            check("vld_while_busy", 32'(busy == 0), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_vld", 32'd1, 32'd0);
            end else begin
                check("tx_data", 32'(bus.tx_data),
                      32'(exp_q.pop_front()));
`ifdef HEX_ASCII_EN
                if (chars % 2 == 0) started++;
`else
                started++;
`endif
                chars++;
            end
            busy = 10;
        end else if (busy > 0) begin
            busy--;
        end
    end

    task automatic drain(input int maxc);
        int n;
        n    = 0;
        gate = 1'b1;
        while ((exp_q.size() != 0 || busy != 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_tx_vld", 32'(bus.tx_vld), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        gate  = 1'b1;
        repeat (2) @(negedge clk);

        // write at cycle N, load strobe expected at N+2
        wr(8'hA5);
        check("lat_n1_vld", 32'(bus.tx_vld), 32'd0);
        @(negedge clk);
        check("lat_n2_vld", 32'(bus.tx_vld), 32'd1);
`ifdef HEX_ASCII_EN
        check("lat_n2_data", 32'(bus.tx_data), 32'h41);
`else
        check("lat_n2_data", 32'(bus.tx_data), 32'hA5);
`endif
        drain(200);

        gate = 1'b0;
        for (int i = 0; i < 16; i++) wr(8'(i));
        check("burst_count", 32'(bus.count), 32'd16);
        check("burst_full", 32'(bus.full), 32'd1);
        check("burst_empty", 32'(bus.empty), 32'd0);
        wr(8'hFF);
        check("ovf_set", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd16);
        drain(2000);

        gate = 1'b0;
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        check("simul_pre", 32'(bus.count), 32'd3);
        gate = 1'b1;
        wr(8'h44);
        gate = 1'b0;
        check("simul_post", 32'(bus.count), 32'd3);
        drain(500);

        for (int c = 0; c < 400; c++) begin
            gate = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1 && pushed - started < DEPTH)
                wr(8'($urandom));
            else
                @(negedge clk);
        end
        drain(4000);

        wr(8'h3A);
        wr(8'hF0);
        drain(200);

        // reset while the FSM waits in HOLD with bytes queued
        gate = 1'b1;
        wr(8'h5C);
        n = 0;
        while (!bus.tx_vld && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_vld_seen", 32'(n < 20), 32'd1);
        wr(8'h01);
        wr(8'h02);
        wr(8'h03);
        wr(8'h04);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 32'(bus.tx_vld), 32'd0);
        check("mid_rst_data", 32'(bus.tx_data), 32'd0);
        check("mid_rst_empty", 32'(bus.empty), 32'd1);
        check("mid_rst_full", 32'(bus.full), 32'd0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_ovf", 32'(bus.overflow), 32'd0);
        exp_q.delete();
        pushed  = 0;
        started = 0;
        chars   = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_empty", 32'(bus.empty), 32'd1);
        wr(8'h7E);
        drain(200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes (power of two, 4..256).
REQ-002 SHALL have parameter ADDR_W, default 4, log2(DEPTH).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_data  input  8  byte from upstream producer (EEPROM read controller).
REQ-006 SHALL have port wr_en  input  1  write strobe; one byte per high cycle.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-008 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-009 SHALL have port count  output  ADDR_W+1  bytes currently stored.
REQ-010 SHALL have port overflow  output  1  sticky; set by any write attempted while full.
REQ-011 SHALL have port tx_data  output  8  character to UART transmitter din.
REQ-012 SHALL have port tx_vld  output  1  one-cycle load strobe to UART transmitter din_vld.
REQ-013 SHALL have port tx_rdy  input  1  UART transmitter idle/ready (low while loading or shifting).

Function
REQ-014 SHALL store bytes in a DEPTH-entry circular FIFO; write and read pointers ADDR_W+1 bits, wrap modulo 2*DEPTH.
REQ-015 SHALL register full, empty, count from pointers; all three valid the cycle after the causing edge.
REQ-016 SHALL drop wr_en while full, even if a pop occurs same cycle; set overflow; stored data unchanged.
REQ-017 SHALL accept simultaneous write and pop when not full; count unchanged.
REQ-018 SHALL implement FSM states IDLE, SEND, HOLD.
REQ-019 IDLE: when !empty and tx_rdy, latch head byte into internal byte_reg, advance read pointer, go SEND; else stay.
REQ-020 SEND: tx_vld=1 for exactly one cycle, tx_data stable; next state HOLD.
REQ-021 HOLD: stay while tx_rdy=0; on tx_rdy=1 go IDLE (or SEND for second character, REQ-029).
REQ-022 tx_vld SHALL be high only in SEND; never two tx_vld cycles without an intervening tx_rdy=0 cycle in HOLD.
REQ-023 tx_data SHALL hold its value from SEND until the next SEND.
REQ-024 Latency: empty FIFO, IDLE, tx_rdy=1, wr_en at cycle N -> tx_vld high at cycle N+2.
REQ-025 Byte order SHALL be strict FIFO; no byte lost or duplicated while overflow=0.
REQ-026 tx_rdy dropping in IDLE SHALL block the pop; no partial transfer.

Reset
REQ-027 rst_n low SHALL immediately force: pointers 0, count 0, empty 1, full 0, overflow 0, tx_vld 0, tx_data 8'h00, state IDLE; mid-transfer data discarded.
REQ-028 First pop after reset release SHALL require a new write.

Configuration
REQ-029 Macro HEX_ASCII_EN defined: each popped byte SHALL be sent as two ASCII uppercase hex chars, high nibble first (0-9 -> 8'h30+n, A-F -> 8'h41+n-10); HOLD after first char returns to SEND with low nibble, after second to IDLE; one FIFO pop per two tx_vld.
REQ-030 Macro HEX_ASCII_EN undefined: raw byte sent as single character; one tx_vld per pop; nibble logic absent.

Verification
REQ-031 Write 8'hA5 into empty FIFO, tx_rdy=1 -> tx_vld at N+2, tx_data=8'hA5 (raw) or 8'h41 then 8'h35 (HEX_ASCII_EN).
REQ-032 Burst 16 writes 8'h00..8'h0F with tx_rdy=0 -> full=1, count=16; 17th write -> overflow=1, data 8'h00..8'h0F emitted in order once tx_rdy=1.
REQ-033 UART model holding tx_rdy low 10 cycles after each tx_vld -> exactly one tx_vld per busy window, no tx_vld while tx_rdy=0.
REQ-034 Simultaneous wr_en and pop at count=3 -> count stays 3, order preserved.
REQ-035 Assert rst_n low during HOLD with 4 bytes queued -> all outputs at reset values, no tx_vld until new write.
REQ-036 HEX_ASCII_EN: write 8'h3A, 8'hF0 -> tx_data sequence 8'h33, 8'h41, 8'h46, 8'h30.
